sel_mux_pipe: RTL and testbench
===============================

// Module: sel_mux_pipe
// PURPOSE
//  Parametrised N:1 select stage with a registered output and a valid/ready handshake.
//  The stage is a two-entry skid buffer, so it holds one transfer per clock without
//  stalling the upstream.
//  Replaces fixed-width combinational 2:1 selects in the CPU datapath, such as the
//  register-destination and write-back selects, wherever the select sits on a pipeline
//  boundary.
//  Adds three things a plain mux lacks: back-pressure, flush and out-of-range select
//  detection.
// PARAMETERS
//  WIDTH        5               bits per data channel
//  NUM_IN       2               number of input channels (>=2)
//  SEL_W        $clog2(NUM_IN)  select width; derived, do not override
//  DEFAULT_VAL  {WIDTH{1'b0}}   data driven when sel >= NUM_IN
// PORTS
//  clk        in   1             rising-edge clock
//  rst        in   1             synchronous reset, active-high
//  flush      in   1             synchronous flush of all buffered entries
//  in_valid   in   1             upstream presents a transfer
//  in_ready   out  1             stage can accept a transfer
//  in_sel     in   SEL_W         channel select for this transfer
//  in_data    in   NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
//  out_valid  out  1             out_* fields hold a transfer
//  out_ready  in   1             downstream accepts a transfer
//  out_data   out  WIDTH         selected channel, registered
//  out_sel    out  SEL_W         select that produced out_data
//  out_err    out  1             in_sel was >= NUM_IN; out_data = DEFAULT_VAL
// BEHAVIOUR
//  - Handshake:
//    - A transfer occurs when valid && ready on a rising clk edge.
//    - Once out_valid is asserted, out_* are stable until the transfer completes.
//  - Selection: mux, range check and DEFAULT_VAL substitution happen combinationally
//    on the input side. The {data, sel, err} result is what gets stored.
//  - Latency: an accepted input appears on out_* exactly 1 cycle later when the stage
//    is empty. Throughput is 1 transfer per cycle while out_ready = 1.
//  - States (2-bit) and transitions:
//    - EMPTY: out_valid=0, in_ready=1.
//      - Accept -> FULL.
//    - FULL: out reg valid, in_ready=1.
//      - Accept with no drain -> SKID (new entry goes to the skid reg).
//      - Drain with no accept -> EMPTY.
//      - Accept and drain together -> FULL, out reg loads the new entry.
//    - SKID: both regs valid, in_ready=0.
//      - Drain -> FULL, skid reg moves into the out reg.
//  - in_ready depends only on state. There is no combinational path from out_ready
//    to in_ready.
//  - Reset (rst=1 at an edge):
//    - Next state EMPTY; out_valid=0, out_data=0, out_sel=0, out_err=0.
//    - in_ready=0 while rst is high, 1 in the first cycle after.
//    - Reset mid-operation discards both entries silently.
//  - Flush (rst=0, flush=1):
//    - Next state EMPTY and out_valid=0. out_data, out_sel and out_err keep their
//      values; they are don't-care while out_valid=0.
//    - An input offered in the flush cycle is not accepted.
//    - The downstream must treat a flush-cycle drain as killed.
//  - Priority: rst > flush > handshake.
//  - Out-of-range select: in_sel >= NUM_IN (possible when NUM_IN is not a power of 2)
//    is still accepted. It produces out_data=DEFAULT_VAL, out_err=1, and out_sel
//    carries the raw in_sel.
//  - in_data and in_sel are sampled only on accept; their values otherwise are
//    don't-care.
// STRUCTURE
//  - Shared package cpu_pipe_pkg holds:
//    - the state encoding: ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2;
//    - typedef of the entry {err, sel, data} as a macro/width constant for reuse by
//      other pipe stages.
//  - One sub-module, pipe_skid_reg: the generic two-entry skid buffer carrying a
//    WIDTH+SEL_W+1 payload. The mux and range check stay in sel_mux_pipe.
//  - ST_SKID=2'd2 is the only other state encoding used; 2'd3 is illegal and
//    recovers to EMPTY.
// TESTING
//  1. WIDTH=5, NUM_IN=2, drive rst then hold out_ready=1. Stream sel=1 with ch1=5'h1F,
//     then sel=0 with ch0=5'h0A.
//     -> out_data is 1F then 0A, each 1 cycle after its accept, with no bubbles.
//  2. Fill with 2 transfers while out_ready=0.
//     -> in_ready=0 in SKID and out_* are stable. Then set out_ready=1.
//     -> both entries drain in order over 2 cycles and in_ready returns to 1.
//  3. NUM_IN=3, in_sel=2'd3 with in_valid.
//     -> out_err=1, out_data=DEFAULT_VAL, out_sel=3. The next legal sel clears
//        out_err.
//  4. In SKID, assert flush together with in_valid.
//     -> next cycle out_valid=0 and in_ready=1, and the flush-cycle input never
//        appears on out_*.
//  5. Assert rst mid-stream with out_valid=1.
//     -> next cycle out_valid=0 and out_data=0. in_ready=0 during rst and 1 after.
//  6. Random valid/ready over 10k cycles with a scoreboard.
//     -> output order and data match the input exactly, with no loss and no
//        duplication.

Source files
------------

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for CPU pipeline-boundary stages: the skid buffer state
// encoding and the width of the {err, sel, data} entry they carry.
package cpu_pipe_pkg;

   // Skid buffer occupancy states; 2'd3 is never entered and recovers to EMPTY.
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_FULL  = 2'd1;
   localparam logic [1:0] ST_SKID  = 2'd2;

   // Width of one stored entry {err, sel, data}.
   function automatic int entry_width(input int width, input int sel_w);
      return width + sel_w + 1;
   endfunction

endpackage

// File: rtl/sel_mux_pipe_if.sv
// Handshake bundle for the select stage: input-side valid/ready with select and
// packed channel data, output-side valid/ready with the registered result, and flush.
interface sel_mux_pipe_if #(
   parameter int WIDTH  = 5,
   parameter int NUM_IN = 2,
   parameter int SEL_W  = $clog2(NUM_IN)
);
   logic                    flush;
   logic                    in_valid;
   logic                    in_ready;
   logic [SEL_W-1:0]        in_sel;
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_sel;
   logic                    out_err;

   // Stage view: consumes the input side, produces the output side.
   modport slave (
      input  flush, in_valid, in_sel, in_data, out_ready,
      output in_ready, out_valid, out_data, out_sel, out_err
   );

   // Environment view: upstream producer plus downstream consumer.
   modport master (
      output flush, in_valid, in_sel, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_sel, out_err
   );
endinterface

// File: rtl/pipe_skid_reg.sv
// Generic two-entry skid buffer. The out register feeds the downstream directly;
// the skid register catches the one extra entry accepted while the downstream
// stalls, so in_ready never depends combinationally on out_ready.
module pipe_skid_reg
   import cpu_pipe_pkg::*;
#(
   parameter int PAYLOAD_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [PAYLOAD_W-1:0] in_payload,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [PAYLOAD_W-1:0] out_payload
);

   logic [1:0]           state_r;
   logic [1:0]           state_nxt_s;
   logic [PAYLOAD_W-1:0] out_r;
   logic [PAYLOAD_W-1:0] skid_r;
   logic                 out_valid_r;
   logic                 accept_s;
   logic                 drain_s;
   logic                 load_out_new_s;
   logic                 load_out_skid_s;
   logic                 load_skid_s;

   // Ready is a decode of the state register alone, held low during reset.
   assign in_ready    = !rst && ((state_r == ST_EMPTY) || (state_r == ST_FULL));
   assign accept_s    = in_valid && in_ready;
   assign drain_s     = out_valid_r && out_ready;
   assign out_valid   = out_valid_r;
   assign out_payload = out_r;

   // Next-state and register load selection from accept/drain events.
   always_comb begin
      state_nxt_s     = state_r;
      load_out_new_s  = 1'b0;
      load_out_skid_s = 1'b0;
      load_skid_s     = 1'b0;
      case (state_r)
         ST_EMPTY: begin
            if (accept_s) begin
               state_nxt_s    = ST_FULL;
               load_out_new_s = 1'b1;
            end else begin
               state_nxt_s = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (accept_s && drain_s) begin
               state_nxt_s    = ST_FULL;
               load_out_new_s = 1'b1;
            end else if (accept_s) begin
               state_nxt_s = ST_SKID;
               load_skid_s = 1'b1;
            end else if (drain_s) begin
               state_nxt_s = ST_EMPTY;
            end else begin
               state_nxt_s = ST_FULL;
            end
         end
         ST_SKID: begin
            if (drain_s) begin
               state_nxt_s     = ST_FULL;
               load_out_skid_s = 1'b1;
            end else begin
               state_nxt_s = ST_SKID;
            end
         end
         default: begin
            state_nxt_s = ST_EMPTY;
         end
      endcase
   end

   // State and entry registers; reset clears everything, flush only drops validity.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_EMPTY;
         out_valid_r <= 1'b0;
         out_r       <= {PAYLOAD_W{1'b0}};
         skid_r      <= {PAYLOAD_W{1'b0}};
      end else if (flush) begin
         state_r     <= ST_EMPTY;
         out_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         out_valid_r <= (state_nxt_s == ST_FULL) || (state_nxt_s == ST_SKID);
         if (load_out_new_s) begin
            out_r <= in_payload;
         end else if (load_out_skid_s) begin
            out_r <= skid_r;
         end
         if (load_skid_s) begin
            skid_r <= in_payload;
         end
      end
   end

endmodule

// File: rtl/sel_mux_pipe.sv
// N:1 select stage on a pipeline boundary. The mux, range check and default
// substitution happen on the input side; the resulting {err, sel, data} entry
// is stored in a two-entry skid buffer that drives the registered outputs.
module sel_mux_pipe
   import cpu_pipe_pkg::*;
#(
   parameter int               WIDTH       = 5,
   parameter int               NUM_IN      = 2,
   parameter int               SEL_W       = $clog2(NUM_IN),
   parameter logic [WIDTH-1:0] DEFAULT_VAL = {WIDTH{1'b0}}
) (
   input  logic         clk,
   input  logic         rst,
   sel_mux_pipe_if.slave bus
);

   localparam int ENTRY_W = entry_width(WIDTH, SEL_W);

   logic [WIDTH-1:0]   sel_data_s;
   logic               sel_err_s;
   logic [ENTRY_W-1:0] in_entry_s;
   logic [ENTRY_W-1:0] out_entry_s;

   // Channel select; a select matching no channel yields DEFAULT_VAL and err.
   always_comb begin
      sel_data_s = DEFAULT_VAL;
      sel_err_s  = 1'b1;
      for (int i = 0; i < NUM_IN; i++) begin
         if (bus.in_sel == SEL_W'(i)) begin
            sel_data_s = bus.in_data[i*WIDTH +: WIDTH];
            sel_err_s  = 1'b0;
         end else begin
            sel_data_s = sel_data_s;
         end
      end
   end

   assign in_entry_s = {sel_err_s, bus.in_sel, sel_data_s};

   pipe_skid_reg #(
      .PAYLOAD_W (ENTRY_W)
   ) u_skid (
      .clk         (clk),
      .rst         (rst),
      .flush       (bus.flush),
      .in_valid    (bus.in_valid),
      .in_ready    (bus.in_ready),
      .in_payload  (in_entry_s),
      .out_valid   (bus.out_valid),
      .out_ready   (bus.out_ready),
      .out_payload (out_entry_s)
   );

   assign bus.out_err  = out_entry_s[ENTRY_W-1];
   assign bus.out_sel  = out_entry_s[WIDTH +: SEL_W];
   assign bus.out_data = out_entry_s[WIDTH-1:0];

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Self-checking bench for sel_mux_pipe (WIDTH=5, NUM_IN=3): directed scenarios
// with literal expectations plus a randomized run against a queue-based model.
module tb_sel_mux_pipe;
   localparam int               W   = 5;
   localparam int               N   = 3;
   localparam int               SW  = 2;
   localparam logic [W-1:0]     DEF = 5'h12;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sel_mux_pipe_if #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW)) bus ();

   sel_mux_pipe #(
      .WIDTH       (W),
      .NUM_IN      (N),
      .SEL_W       (SW),
      .DEFAULT_VAL (DEF)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;
   logic [W+SW:0] q[$];   // expected entries {err, sel, data}, oldest first

   // Expected entry from the select rule: in-range picks channel sel, else default+err.
   function automatic logic [W+SW:0] mk(input logic [SW-1:0] s, input logic [N*W-1:0] d);
      logic [W-1:0] v;
      if (int'(s) < N) begin
         v = W'(d >> (int'(s) * W));
         return {1'b0, s, v};
      end
      return {1'b1, s, DEF};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic go();
      @(posedge clk);
      #1;
   endtask

   // Behavioural model: a FIFO of at most two entries with rst/flush clearing it.
   always @(posedge clk) begin
      if (rst) begin
         q.delete();
         chk_en <= 1'b1;
      end else if (bus.flush) begin
         q.delete();
      end else if (q.size() > 0 && bus.out_ready) begin
         if (bus.in_valid && q.size() < 2) q.push_back(mk(bus.in_sel, bus.in_data));
         void'(q.pop_front());
      end else if (bus.in_valid && q.size() < 2) begin
         q.push_back(mk(bus.in_sel, bus.in_data));
      end
   end

   // Every-cycle comparison of DUT outputs against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_in_ready", 32'(bus.in_ready), 32'(!rst && q.size() < 2));
         chk("m_out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
         if (q.size() > 0) begin
            chk("m_out_data", 32'(bus.out_data), 32'(q[0][W-1:0]));
            chk("m_out_sel", 32'(bus.out_sel), 32'(q[0][W+SW-1:W]));
            chk("m_out_err", 32'(bus.out_err), 32'(q[0][W+SW]));
         end
      end
   end

   initial begin
      bus.flush = 1'b0; bus.in_valid = 1'b0; bus.in_sel = 2'd0;
      bus.in_data = 15'h0000; bus.out_ready = 1'b0;

      // Reset
      go(); go();
      @(negedge clk);
      chk("rst_in_ready_low", 32'(bus.in_ready), 32'h0);
      go(); rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready_after", 32'(bus.in_ready), 32'h1);
      chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_out_data", 32'(bus.out_data), 32'h0);
      chk("rst_out_sel", 32'(bus.out_sel), 32'h0);
      chk("rst_out_err", 32'(bus.out_err), 32'h0);

      // 1: streaming with no bubbles
      go();
      bus.out_ready = 1'b1;
      bus.in_data = {5'h07, 5'h1F, 5'h0A};
      bus.in_valid = 1'b1; bus.in_sel = 2'd1;
      go();
      bus.in_sel = 2'd0;
      @(negedge clk);
      chk("t1_first", 32'(bus.out_data), 32'h1F);
      go();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("t1_second", 32'(bus.out_data), 32'h0A);
      chk("t1_second_valid", 32'(bus.out_valid), 32'h1);
      go();
      @(negedge clk);
      chk("t1_drained", 32'(bus.out_valid), 32'h0);

      // 2: fill to SKID under back-pressure, then drain in order
      go();
      bus.out_ready = 1'b0;
      bus.in_data = {5'h15, 5'h11, 5'h03};
      bus.in_valid = 1'b1; bus.in_sel = 2'd0;
      go();
      bus.in_sel = 2'd2;
      go();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("t2_skid_ready", 32'(bus.in_ready), 32'h0);
      chk("t2_head", 32'(bus.out_data), 32'h03);
      go();
      @(negedge clk);
      chk("t2_stable", 32'(bus.out_data), 32'h03);
      bus.out_ready = 1'b1;
      go();
      @(negedge clk);
      chk("t2_second", 32'(bus.out_data), 32'h15);
      chk("t2_ready_back", 32'(bus.in_ready), 32'h1);
      go();
      @(negedge clk);
      chk("t2_empty", 32'(bus.out_valid), 32'h0);

      // 3: out-of-range select
      go();
      bus.in_data = {5'h0C, 5'h1B, 5'h04};
      bus.in_valid = 1'b1; bus.in_sel = 2'd3;
      go();
      bus.in_sel = 2'd1;
      @(negedge clk);
      chk("t3_err", 32'(bus.out_err), 32'h1);
      chk("t3_default", 32'(bus.out_data), 32'(DEF));
      chk("t3_sel", 32'(bus.out_sel), 32'h3);
      go();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("t3_err_clear", 32'(bus.out_err), 32'h0);
      chk("t3_legal_data", 32'(bus.out_data), 32'h1B);

      // 4: flush in SKID with a concurrent input
      go();
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_sel = 2'd0;
      go();
      bus.in_sel = 2'd1;
      go();
      bus.in_data = {5'h19, 5'h1B, 5'h04};
      bus.in_sel = 2'd2; bus.flush = 1'b1;
      go();
      bus.flush = 1'b0; bus.in_valid = 1'b0;
      @(negedge clk);
      chk("t4_flushed_valid", 32'(bus.out_valid), 32'h0);
      chk("t4_flushed_ready", 32'(bus.in_ready), 32'h1);
      bus.out_ready = 1'b1;
      go(); go();
      @(negedge clk);
      chk("t4_no_ghost", 32'(bus.out_valid), 32'h0);

      // 5: reset mid-stream
      go();
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1; bus.in_sel = 2'd1;
      go();
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("t5_valid_before", 32'(bus.out_valid), 32'h1);
      rst = 1'b1;
      go();
      @(negedge clk);
      chk("t5_valid_after", 32'(bus.out_valid), 32'h0);
      chk("t5_data_after", 32'(bus.out_data), 32'h0);
      chk("t5_ready_in_rst", 32'(bus.in_ready), 32'h0);
      go();
      rst = 1'b0;
      @(negedge clk);
      chk("t5_ready_after", 32'(bus.in_ready), 32'h1);

      // 6: randomized traffic against the model
      for (int i = 0; i < 10000; i++) begin
         go();
         bus.in_valid  = 1'($urandom_range(0, 1));
         bus.in_sel    = 2'($urandom_range(0, 3));
         bus.in_data   = 15'($urandom);
         bus.out_ready = ($urandom_range(0, 3) != 0);
         bus.flush     = ($urandom_range(0, 63) == 0);
      end
      go();
      bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
      repeat (4) go();
      @(negedge clk);
      chk("end_drained", 32'(bus.out_valid), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
